// File: rtl/onchip_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_arb_pkg
// Shared types and default sizes for the on-chip RAM arbiter.
//   arb_state_e : top-level arbitration / lock / zero-fill state
//   req_id_t    : requester identifier (m0 = NIOS bridge, m1 = data logger)
//   DEF_*       : default RAM geometry (32-bit words, 17-bit address, 75000 words)
// -----------------------------------------------------------------------------
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 75000;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2,
    CLEAR = 2'd3
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_M0 = 1'b0;
  localparam req_id_t REQ_M1 = 1'b1;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin grant with a lock hold.
//   clk, reset : clock, synchronous active-high reset
//   en         : arbitration allowed this cycle (0 = grant nobody)
//   req[1:0]   : request vector, bit N = requester mN
//   hold       : lock active, only hold_id may be granted
//   hold_id    : requester that owns the lock
//   gnt_vld    : a requester is granted this cycle (combinational)
//   gnt_id     : granted requester
// last_grant resets to m1 so that m0 wins the first tie.
// -----------------------------------------------------------------------------
module rr_arbiter2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       hold,
  input  req_id_t    hold_id,
  output logic       gnt_vld,
  output req_id_t    gnt_id
);

  req_id_t last_grant_q, last_grant_d;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = REQ_M0;
    if (en) begin
      if (hold) begin
        gnt_vld = req[hold_id];
        gnt_id  = hold_id;
      end else begin
        case (req)
          2'b01: begin
            gnt_vld = 1'b1;
            gnt_id  = REQ_M0;
          end
          2'b10: begin
            gnt_vld = 1'b1;
            gnt_id  = REQ_M1;
          end
          2'b11: begin
            // Tie: the requester that did not win last time goes first.
            gnt_vld = 1'b1;
            gnt_id  = ~last_grant_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_vld) last_grant_d = gnt_id;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= REQ_M1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port on-chip RAM (1-cycle read latency) between m0 (NIOS
// bridge) and m1 (balance-loop data logger). Round-robin arbitration, optional
// lock for read-modify-write, built-in zero-fill sequencer, sticky
// out-of-range flag.
//   mN_req/write/addr/be/wdata/lock : requester N access, held until mN_ack
//   mN_ack                          : access accepted this cycle (combinational)
//   mN_rvalid/mN_rdata              : read return, one cycle after read ack
//   clear_start/busy/done           : zero-fill control and status
//   addr_err/err_clr                : sticky out-of-range flag and its clear
//   mem_*                           : RAM slave port, combinational from grant
// -----------------------------------------------------------------------------
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int DEPTH          = DEF_DEPTH,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_lock,
  output logic                m0_ack,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_ack,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                clear_done,
  output logic                addr_err,
  input  logic                err_clr,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int                BE_W        = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam arb_state_e        RESET_STATE = arb_state_e'(CLEAR_ON_RESET ? CLEAR : ARB);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clear_done_q, clear_done_d;
  logic              addr_err_q, addr_err_d;
  logic [1:0]        rd_tag_q, rd_tag_d;   // one-hot owner of last cycle's read
  logic              rd_oor_q, rd_oor_d;   // that read was out of range

  logic              arb_en;
  logic              hold;
  req_id_t           hold_id;
  logic              gnt_vld;
  req_id_t           gnt_id;

  logic              g_write;
  logic              g_lock;
  logic              g_oor;
  logic [ADDR_W-1:0] g_addr;
  logic [BE_W-1:0]   g_be;
  logic [DATA_W-1:0] g_wdata;

  // Arbitration enable: clear_start pre-empts requests only while unlocked.
  always_comb begin
    arb_en  = 1'b0;
    hold    = 1'b0;
    hold_id = REQ_M0;
    if (!reset) begin
      case (state_q)
        ARB:   arb_en = !clear_start;
        LOCK0: begin
          arb_en  = 1'b1;
          hold    = 1'b1;
          hold_id = REQ_M0;
        end
        LOCK1: begin
          arb_en  = 1'b1;
          hold    = 1'b1;
          hold_id = REQ_M1;
        end
        default: ;
      endcase
    end
  end

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en),
    .req     ({m1_req, m0_req}),
    .hold    (hold),
    .hold_id (hold_id),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    if (gnt_id == REQ_M1) begin
      g_write = m1_write;
      g_lock  = m1_lock;
      g_addr  = m1_addr;
      g_be    = m1_be;
      g_wdata = m1_wdata;
    end else begin
      g_write = m0_write;
      g_lock  = m0_lock;
      g_addr  = m0_addr;
      g_be    = m0_be;
      g_wdata = m0_wdata;
    end
    g_oor = g_addr > LAST_ADDR;
  end

  assign m0_ack = gnt_vld && (gnt_id == REQ_M0);
  assign m1_ack = gnt_vld && (gnt_id == REQ_M1);

  // RAM port: zero-fill writes, or the granted in-range access, else idle.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (!reset && state_q == CLEAR) begin
      mem_address    = clr_cnt_q;
      mem_byteenable = '1;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (gnt_vld && !g_oor) begin
      mem_address    = g_addr;
      mem_byteenable = g_be;
      mem_chipselect = 1'b1;
      mem_write      = g_write;
      mem_writedata  = g_wdata;
    end
  end

  assign mem_clken = 1'b1;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clear_done_d = 1'b0;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (gnt_vld && g_lock) begin
          if (gnt_id == REQ_M1) state_d = LOCK1;
          else                  state_d = LOCK0;
        end
      end
      LOCK0: if ((m0_ack || !m0_req) && !m0_lock) state_d = ARB;
      LOCK1: if ((m1_ack || !m1_req) && !m1_lock) state_d = ARB;
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d      = ARB;
          clr_cnt_d    = '0;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    rd_tag_d   = {m1_ack && !m1_write, m0_ack && !m0_write};
    rd_oor_d   = gnt_vld && !g_write && g_oor;
    addr_err_d = addr_err_q;
    // A new error outranks a simultaneous clear.
    if (gnt_vld && g_oor) addr_err_d = 1'b1;
    else if (err_clr)     addr_err_d = 1'b0;
  end

  // Stage boundary: issue cycle -> return cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_tag_q     <= '0;
      rd_oor_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_done_q <= clear_done_d;
      addr_err_q   <= addr_err_d;
      rd_tag_q     <= rd_tag_d;
      rd_oor_q     <= rd_oor_d;
    end
  end

  assign m0_rvalid  = rd_tag_q[0];
  assign m1_rvalid  = rd_tag_q[1];
  assign m0_rdata   = (rd_tag_q[0] && !rd_oor_q) ? mem_readdata : '0;
  assign m1_rdata   = (rd_tag_q[1] && !rd_oor_q) ? mem_readdata : '0;
  assign clear_busy = (state_q == CLEAR) && !reset;
  assign clear_done = clear_done_q;
  assign addr_err   = addr_err_q;

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port on-chip RAM (32-bit words, 17-bit word address, 75000 words, 1-cycle read latency) between two requesters: m0 (NIOS-side bridge) and m1 (balance-loop data logger).
- Round-robin arbitration with an optional lock for atomic read-modify-write sequences.
- Built-in zero-fill sequencer that clears the whole RAM.
- Sits between the requesters and the RAM slave port.

Parameters:
- ADDR_W, 17, word address width
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 75000, valid words; addresses >= DEPTH are out of range
- CLEAR_ON_RESET, 0, 1 = start zero-fill automatically when reset deasserts

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- mN_req  in  1  request, N in {0,1}; held until mN_ack
- mN_write  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_W  word address
- mN_be  in  DATA_W/8  byte enables
- mN_wdata  in  DATA_W  write data
- mN_lock  in  1  keep ownership after this access
- mN_ack  out  1  access accepted this cycle
- mN_rvalid  out  1  read data valid, 1 cycle after read ack
- mN_rdata  out  DATA_W  read data
- clear_start  in  1  pulse: begin zero-fill
- clear_busy  out  1  zero-fill in progress
- clear_done  out  1  1-cycle pulse when fill completes
- addr_err  out  1  sticky out-of-range flag
- err_clr  in  1  clears addr_err
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  to RAM; constant 1
- mem_readdata  in  DATA_W  RAM q, valid 1 cycle after read issue

Behaviour:
- Reset values: all outputs 0 except mem_clken = 1.
  - last_grant = 1, so m0 wins the first tie.
  - State = CLEAR if CLEAR_ON_RESET, else ARB.
- Reset mid-fill aborts the fill: no clear_done, state returns to its reset value.
- State ARB:
  - Each cycle, grant at most one requester; ack is combinational on the grant cycle.
  - Both requesting: grant !last_grant. Only one requesting: grant it.
  - The grant drives mem_* with chipselect = 1 and mem_write = mN_write, then updates last_grant.
  - If the granted requester has mN_lock = 1 on its ack cycle, go to LOCKN.
  - clear_start has priority over requests: no ack that cycle, go to CLEAR with counter = 0.
- State LOCKN:
  - Only mN is served; the other requester waits.
  - Return to ARB on the first mN ack with mN_lock = 0, or on a cycle where mN_req = 0 and mN_lock = 0.
  - clear_start is ignored while locked.
- State CLEAR:
  - Each cycle writes 0 with byteenable all-ones at address counter, then increments the counter.
  - No acks are given; clear_busy = 1.
  - On the write to address DEPTH-1: next cycle pulse clear_done, go to ARB; clear_busy drops that same cycle.
  - Fill takes exactly DEPTH cycles. clear_start during CLEAR is ignored.
- Reads:
  - A 1-cycle pipeline tag records the owner of the issued read.
  - The next cycle, mN_rvalid = 1 and mN_rdata = mem_readdata (or 0 if out of range).
  - mN_rdata is 0 when not valid.
  - Back-to-back reads from alternating requesters are fully pipelined, one per cycle.
- Out-of-range address (>= DEPTH):
  - The access is acked, but chipselect stays 0 (no RAM access).
  - A write is dropped; a read returns rvalid with 0.
  - addr_err sets the next cycle.
  - If err_clr and a new error occur in the same cycle, set wins.
- mem_* outputs are combinational from the grant. Idle cycles drive chipselect = 0 and address = 0.

Decomposition:
- Package onchip_mem_arb_pkg:
  - state enum {ARB, LOCK0, LOCK1, CLEAR}
  - requester id type
  - default ADDR_W/DATA_W/DEPTH constants
- Sub-module rr_arbiter2: 2-input round-robin grant with last_grant register and lock hold.
- Clear counter and read-return pipeline stay in the top module.

Test Plan:
- After reset, m0 writes 0xDEADBEEF @0x00010 with be=4'hF, then reads it back -> m0_ack on the issue cycles; m0_rvalid the next cycle with 0xDEADBEEF.
- m0 and m1 both request reads continuously -> acks alternate m0, m1, m0, ...; each rvalid goes to the correct requester one cycle later.
- m1 lock: read @5 with lock=1, then write @5 with lock=0 while m0 requests -> m0 receives no ack until after m1's write ack; m0 is then acked the next cycle.
- Write 0x11223344 with be=4'b0101 over 0xFFFFFFFF -> readback 0xFF22FF44.
- m0 write @74999 then read @75000 -> @74999 updated; read returns rvalid with 0; addr_err = 1 until err_clr pulse, then 0.
- Fill 0xA5A5A5A5 at @0 and @74999, pulse clear_start while m1 requests -> clear_busy for 75000 cycles with no acks; clear_done pulse; m1 then acked; both addresses read 0.
